// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial line in, byte/status out, FSM state for debug.
// rx_dv_o is a valid with no ready: the consumer must take rx_byte_o in the one cycle it is high.
interface uart_rx_if;
  logic       rx_serial_i;
  logic       rx_dv_o;
  logic [7:0] rx_byte_o;
  logic       rx_frame_err_o;
  logic       rx_parity_err_o;
  logic       rx_active_o;
  logic [2:0] rx_state_o;

  modport slave (
    input  rx_serial_i,
    output rx_dv_o, rx_byte_o, rx_frame_err_o, rx_parity_err_o, rx_active_o, rx_state_o
  );

  modport master (
    output rx_serial_i,
    input  rx_dv_o, rx_byte_o, rx_frame_err_o, rx_parity_err_o, rx_active_o, rx_state_o
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; defining UART_RX_PARITY_EN adds a parity bit (8E1/8O1 via PARITY_ODD).
// Each good byte is presented with a one-cycle rx_dv_o pulse; errors pulse their own flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input logic      clk_i,
  input logic      rst_n_i,
  uart_rx_if.slave rx_if
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        ferr_q, ferr_d;
  logic        active_q, active_d;
  logic        mismatch;
`ifdef UART_RX_PARITY_EN
  logic        mismatch_q, mismatch_d;
  logic        perr_q, perr_d;
  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      byte_q     <= '0;
      dv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      active_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      mismatch_q <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx_if.rx_serial_i;
      rx_s_q     <= sync1_q;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      byte_q     <= byte_d;
      dv_q       <= dv_d;
      ferr_q     <= ferr_d;
      active_q   <= active_d;
`ifdef UART_RX_PARITY_EN
      mismatch_q <= mismatch_d;
      perr_q     <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    byte_d     = byte_q;
    dv_d       = 1'b0;
    ferr_d     = 1'b0;
    active_d   = active_q;
`ifdef UART_RX_PARITY_EN
    mismatch_d = mismatch_q;
    perr_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      // Re-check the line at mid start bit so short glitches are dropped silently.
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            active_d = 1'b1;
            state_d  = DATA;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          mismatch_d = ((^data_q) ^ rx_s_q) != PARITY_ODD;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
          ferr_d   = ~rx_s_q;
          if (rx_s_q && !mismatch) begin
            dv_d   = 1'b1;
            byte_d = data_q;
          end
`ifdef UART_RX_PARITY_EN
          perr_d = mismatch_q;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // Waiting for a high line here turns a held-low break into a single frame error.
      CLEANUP: begin
        active_d = 1'b0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.rx_dv_o         = dv_q;
  assign rx_if.rx_byte_o       = byte_q;
  assign rx_if.rx_frame_err_o  = ferr_q;
  assign rx_if.rx_active_o     = active_q;
  assign rx_if.rx_state_o      = state_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.rx_parity_err_o = perr_q;
`else
  assign rx_if.rx_parity_err_o = 1'b0;
`endif

endmodule
